// File: rtl/alu_seq_ctrl.sv
// Sequential ALU with start/busy/done handshake, shift-add multiplier and registered flags.
// Optional signed-overflow flag enabled by defining ALU_SEQ_OVF_EN (default build ties ovf to 0).
module alu_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clock_placa,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           comando,
    input  logic [WIDTH-1:0]     x1,
    input  logic [WIDTH-1:0]     x2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   y,
    output logic                 carry_out,
    output logic                 zero,
    output logic                 err,
    output logic                 ovf,
    output logic [1:0]           estado
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0]     WIDTH_V  = (WIDTH + 1)'(WIDTH);
    localparam logic [2*WIDTH-1:0] Y_ZERO   = {(2*WIDTH){1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [4:0]           op_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;

    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       diff_s;
    logic                 shift_big_s;
    logic [2*WIDTH-1:0]   res_s;
    logic                 carry_s;
    logic                 err_s;
    logic                 zero_s;
    logic [2*WIDTH-1:0]   pp_s;
    logic [2*WIDTH-1:0]   prod_next_s;

    assign busy   = (state_r != IDLE);
    assign done   = (state_r == DONE);
    assign estado = state_r;

    // State register
    always_ff @(posedge clock_placa or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (comando == 5'd2) ? MUL : EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: state_next_s = DONE;
            MUL: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = MUL;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    assign sum_s       = {1'b0, a_r} + {1'b0, b_r};
    assign diff_s      = {1'b0, a_r} - {1'b0, b_r};
    assign shift_big_s = ({1'b0, b_r} >= WIDTH_V);
    assign pp_s        = b_r[cnt_r] ? ({{WIDTH{1'b0}}, a_r} << cnt_r) : Y_ZERO;
    assign prod_next_s = acc_r + pp_s;

    // Single-cycle result for every non-multiply opcode; borrow is bit WIDTH of the difference
    always_comb begin
        res_s   = Y_ZERO;
        carry_s = 1'b0;
        err_s   = 1'b0;
        case (op_r)
            5'd0: begin
                res_s   = {{(WIDTH-1){1'b0}}, sum_s};
                carry_s = sum_s[WIDTH];
            end
            5'd1: begin
                res_s   = {{WIDTH{1'b0}}, diff_s[WIDTH-1:0]};
                carry_s = diff_s[WIDTH];
            end
            5'd3: res_s = {{WIDTH{1'b0}}, a_r & b_r};
            5'd4: res_s = {{WIDTH{1'b0}}, a_r | b_r};
            5'd5: res_s = {{WIDTH{1'b0}}, a_r ^ b_r};
            5'd6: res_s = shift_big_s ? Y_ZERO : {{WIDTH{1'b0}}, a_r << b_r};
            5'd7: res_s = shift_big_s ? Y_ZERO : {{WIDTH{1'b0}}, a_r >> b_r};
            default: begin
                res_s = Y_ZERO;
                err_s = 1'b1;
            end
        endcase
        zero_s = err_s ? 1'b0 : (res_s == Y_ZERO);
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_s;

    // Signed overflow: operand signs agree (add) or differ (sub) and the result sign flips
    always_comb begin
        case (op_r)
            5'd0:    ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
            5'd1:    ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
            default: ovf_s = 1'b0;
        endcase
    end
`else
    assign ovf = 1'b0;
`endif

    // Operand capture, multiplier accumulation and result/flag update on entry to DONE
    always_ff @(posedge clock_placa or posedge reset) begin
        if (reset) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            op_r      <= 5'd0;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= Y_ZERO;
            y         <= Y_ZERO;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r   <= x1;
                        b_r   <= x2;
                        op_r  <= comando;
                        cnt_r <= {CW{1'b0}};
                        acc_r <= Y_ZERO;
                    end
                end
                EXEC: begin
                    y         <= res_s;
                    carry_out <= carry_s;
                    zero      <= zero_s;
                    err       <= err_s;
`ifdef ALU_SEQ_OVF_EN
                    ovf       <= ovf_s;
`endif
                end
                MUL: begin
                    acc_r <= prod_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        y         <= prod_next_s;
                        carry_out <= 1'b0;
                        zero      <= (prod_next_s == Y_ZERO);
                        err       <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                        ovf       <= 1'b0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl at WIDTH=4.
module tb_alu_seq_ctrl;

    logic       clock_placa = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] comando;
    logic [3:0] x1;
    logic [3:0] x2;
    logic       busy;
    logic       done;
    logic [7:0] y;
    logic       carry_out;
    logic       zero;
    logic       err;
    logic       ovf;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl #(.WIDTH(4)) dut (
        .clock_placa (clock_placa),
        .reset       (reset),
        .start       (start),
        .comando     (comando),
        .x1          (x1),
        .x2          (x2),
        .busy        (busy),
        .done        (done),
        .y           (y),
        .carry_out   (carry_out),
        .zero        (zero),
        .err         (err),
        .ovf         (ovf),
        .estado      (estado)
    );

    always #5 clock_placa = ~clock_placa;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and check latency, busy span and the DONE-cycle outputs.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] ey, input logic ec,
                          input logic ez, input logic ee, input int elat, input bit inj);
        int lat;
        int bcnt;
        bit seen;
        @(posedge clock_placa); #1;
        check({tag, "_idle_before"}, {31'd0, done} | {30'd0, estado}, 32'd0);
        start = 1'b1; comando = op; x1 = a; x2 = b;
        @(posedge clock_placa); #1;
        start = 1'b0; x1 = 4'h0; x2 = 4'h0; comando = 5'd0;
        lat = 1; bcnt = 0; seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (inj && lat == 2) begin
                    start = 1'b1; comando = 5'd0; x1 = 4'h1; x2 = 4'h1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clock_placa); #1;
                lat++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, bcnt, elat);
        check({tag, "_estado_done"}, {30'd0, estado}, 32'd3);
        check({tag, "_y"}, {24'd0, y}, {24'd0, ey});
        check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        check({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    endtask

    logic exp_ovf;

    initial begin
        reset = 1'b1; start = 1'b0; comando = 5'd0; x1 = 4'h0; x2 = 4'h0;
        repeat (2) @(posedge clock_placa);
        #1;
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_estado", {30'd0, estado}, 32'd0);
        check("rst_flags", {28'd0, carry_out, zero, err, ovf}, 32'd0);
        reset = 1'b0;

        run_op("add_f_1", 5'd0, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        check("add_f_1_ovf", {31'd0, ovf}, 32'd0);
        run_op("sub_3_5", 5'd1, 4'h3, 4'h5, 8'h0E, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        run_op("add_7_1", 5'd0, 4'h7, 4'h1, 8'h08, 1'b0, 1'b0, 1'b0, 2, 1'b0);
`ifdef ALU_SEQ_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        check("add_7_1_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        run_op("mul_f_f", 5'd2, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        check("mul_ovf", {31'd0, ovf}, 32'd0);
        run_op("mul_3_5", 5'd2, 4'h3, 4'h5, 8'h0F, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_op("illegal", 5'b11111, 4'h3, 4'h4, 8'h00, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        run_op("and_a_5", 5'd3, 4'hA, 4'h5, 8'h00, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        run_op("or_a_4", 5'd4, 4'hA, 4'h4, 8'h0E, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        run_op("xor_c_6", 5'd5, 4'hC, 4'h6, 8'h0A, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        run_op("shl_3_2", 5'd6, 4'h3, 4'h2, 8'h0C, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        run_op("shr_9_4", 5'd7, 4'h9, 4'h4, 8'h00, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        run_op("shl_f_1", 5'd6, 4'hF, 4'h1, 8'h0E, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        run_op("shr_c_2", 5'd7, 4'hC, 4'h2, 8'h03, 1'b0, 1'b0, 1'b0, 2, 1'b0);

        // Reset during the second multiply cycle must take effect without a clock edge.
        @(posedge clock_placa); #1;
        start = 1'b1; comando = 5'd2; x1 = 4'hF; x2 = 4'hF;
        @(posedge clock_placa); #1;
        start = 1'b0;
        check("mrst_in_mul", {30'd0, estado}, 32'd2);
        @(posedge clock_placa); #2;
        reset = 1'b1;
        #1;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_estado", {30'd0, estado}, 32'd0);
        check("mrst_y", {24'd0, y}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        @(posedge clock_placa); #1;
        check("mrst_no_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        run_op("add_1_1", 5'd0, 4'h1, 4'h1, 8'h02, 1'b0, 1'b0, 1'b0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
